// File: rtl/ex_muldiv_unit.sv
// rtl/ex_muldiv_unit.sv - iterative RV32M multiply/divide unit; MULDIV_FAST_MUL_EN selects a single-cycle multiply
module ex_muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_start,
    input  logic [2:0]      i_funct3,
    input  logic [XLEN-1:0] i_rs1,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [4:0]      i_rd,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_valid,
    output logic [XLEN-1:0] o_result,
    output logic [4:0]      o_rd
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);

    state_t           state, state_nxt;
    logic [2:0]       op_q;
    logic             neg_res_q, neg_rem_q;
    logic [XLEN-1:0]  a_q, b_q, hi_q;
    logic [CNT_W-1:0] cnt_q;

    logic             sign_a, sign_b;
    logic [XLEN-1:0]  abs_a, abs_b;
    logic             div_zero, div_ovf, special, fast_mul_op, fast_path;
    logic [XLEN-1:0]  special_res, capture_res;

    always_comb begin
        sign_a = 1'b0;
        sign_b = 1'b0;
        case (i_funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sign_a = i_rs1[XLEN-1];
                sign_b = i_rs2[XLEN-1];
            end
            3'd2:    sign_a = i_rs1[XLEN-1];
            default: ;
        endcase
    end

    assign abs_a = sign_a ? -i_rs1 : i_rs1;
    assign abs_b = sign_b ? -i_rs2 : i_rs2;

    // Divide-by-zero and signed overflow bypass the iteration entirely.
    assign div_zero = i_funct3[2] && (i_rs2 == '0);
    assign div_ovf  = i_funct3[2] && !i_funct3[0] && (i_rs1 == MIN_NEG) && (i_rs2 == '1);
    assign special  = div_zero || div_ovf;

    always_comb begin
        special_res = '0;
        if (div_zero)
            special_res = i_funct3[1] ? i_rs1 : '1;
        else
            special_res = i_funct3[1] ? '0 : MIN_NEG;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN+1:0] fast_prod;
    logic        [XLEN-1:0]   fast_res;

    always_comb begin
        fast_prod = $signed({sign_a, i_rs1}) * $signed({sign_b, i_rs2});
        fast_res  = (i_funct3[1:0] == 2'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end

    assign fast_mul_op = !i_funct3[2];
    assign capture_res = special ? special_res : fast_res;
`else
    assign fast_mul_op = 1'b0;
    assign capture_res = special_res;
`endif

    assign fast_path = special || fast_mul_op;

    // One iteration step: shift-add for multiply, restoring subtract for divide.
    logic [XLEN:0]     mul_add, div_shift, div_diff;
    logic              q_bit;
    logic [XLEN-1:0]   mul_hi_nxt, mul_a_nxt, div_hi_nxt, div_a_nxt;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quot_s, rem_s, final_res;

    always_comb begin
        mul_add    = {1'b0, hi_q} + (a_q[0] ? {1'b0, b_q} : '0);
        mul_hi_nxt = mul_add[XLEN:1];
        mul_a_nxt  = {mul_add[0], a_q[XLEN-1:1]};

        div_shift  = {hi_q, a_q[XLEN-1]};
        div_diff   = div_shift - {1'b0, b_q};
        q_bit      = !div_diff[XLEN];
        div_hi_nxt = q_bit ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_a_nxt  = {a_q[XLEN-2:0], q_bit};

        prod   = {mul_hi_nxt, mul_a_nxt};
        prod_s = neg_res_q ? -prod : prod;
        quot_s = neg_res_q ? -div_a_nxt : div_a_nxt;
        rem_s  = neg_rem_q ? -div_hi_nxt : div_hi_nxt;

        case (op_q)
            3'd0:             final_res = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_res = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_res = quot_s;
            default:          final_res = rem_s;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (i_start && !i_flush) state_nxt = fast_path ? DONE : CALC;
            CALC: begin
                if (i_flush)
                    state_nxt = IDLE;
                else if (cnt_q == LAST_CNT)
                    state_nxt = DONE;
            end
            DONE: if (i_flush || !i_stall) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            op_q      <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            hi_q      <= '0;
            cnt_q     <= '0;
            o_result  <= '0;
            o_rd      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start && !i_flush) begin
                        op_q      <= i_funct3;
                        neg_res_q <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        a_q       <= abs_a;
                        b_q       <= abs_b;
                        hi_q      <= '0;
                        cnt_q     <= '0;
                        o_rd      <= i_rd;
                        if (fast_path)
                            o_result <= capture_res;
                    end
                end
                CALC: begin
                    if (!i_flush) begin
                        a_q   <= op_q[2] ? div_a_nxt : mul_a_nxt;
                        hi_q  <= op_q[2] ? div_hi_nxt : mul_hi_nxt;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT)
                            o_result <= final_res;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_valid = (state == DONE);
    assign o_busy  = (state == IDLE && i_start && !i_flush) || (state == CALC) ||
                     (state == DONE && i_stall);

endmodule
